reg_32b_serial_tx: RTL and testbench
====================================

// Module: reg_32b_serial_tx
// PURPOSE
//  Reads a 32-bit word taken from a processor register (the reg_32b output).
//  Shifts the word out MSB-first on a 3-wire link (sclk/sdata/frame) to the
//  off-chip unlock-mechanism controller. This block is the read/transmit end
//  of that register's data path.
//  Accepts one word per valid/ready handshake and pulses done when the frame
//  is complete.
// PARAMETERS
//  WIDTH    32  bits per frame; must be >= 2
//  CLK_DIV  4   clock cycles per sclk half-period; must be >= 1
// PORTS
//  clock     in   1      system clock; all logic on the rising edge
//  clear     in   1      synchronous, active-high reset
//  in_valid  in   1      data_in holds a word to send
//  in_ready  out  1      block can accept a word (high only in IDLE)
//  data_in   in   WIDTH  word to transmit, normally a reg_32b out
//  abort     in   1      drop the current frame, no done pulse
//  sclk      out  1      serial clock; receiver samples on the rising edge
//  sdata     out  1      serial data; changes only while sclk is low
//  frame     out  1      high for the whole frame
//  done      out  1      one-cycle pulse at frame completion
// BEHAVIOUR
//  - Reset: one clock edge with clear=1 puts the block in IDLE.
//    sclk=0, sdata=0, frame=0, done=0, in_ready=1. All counters and the shift
//    register go to 0. clear overrides every other input.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - in_ready = (state==IDLE), combinational from state.
//  - Accept happens on an edge where in_valid && in_ready.
//    data_in is captured into the shift register and the state goes to SHIFT.
//    The cycle after accept: frame=1, sclk=0, sdata=data_in[WIDTH-1].
//    After accept, data_in is don't-care.
//  - SHIFT: a divide counter runs 0..CLK_DIV-1. When it wraps, sclk toggles.
//    On a 1->0 toggle, the shift register shifts left, sdata takes the next
//    bit, and bit_cnt increments.
//    The 1->0 toggle that ends bit WIDTH-1 goes to DONE: sclk=0, sdata=0.
//  - SHIFT lasts exactly 2*CLK_DIV*WIDTH cycles.
//  - DONE: one cycle, done=1, frame=0. Then IDLE.
//    done is high in cycle 2*CLK_DIV*WIDTH+1 after the accept edge.
//  - Minimum frame gap: frame is low for >= 2 cycles (DONE + IDLE).
//  - abort in SHIFT: next edge goes to IDLE with sclk=0, sdata=0, frame=0.
//    No done pulse.
//  - abort in IDLE or DONE is ignored. If abort and accept happen on the same
//    edge, the accept wins.
//  - in_valid while not in IDLE is ignored. It is not queued and does not
//    corrupt the frame.
//  - Counter widths: div_cnt is $clog2(CLK_DIV)+1 bits, bit_cnt is
//    $clog2(WIDTH)+1 bits. Both are cleared on every accept.
//    Neither wraps outside SHIFT.
//  - All outputs are registered except in_ready.
// STRUCTURE
//  - State encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2) are defined
//    in the shared include serial_defs.vh. The future serial RX block reuses
//    them.
//  - Sub-module tick_div (parameter DIV): a synchronous counter that emits a
//    one-cycle tick every DIV cycles while en=1. It restarts when en=0 or
//    clear=1.
//  - Top level holds the FSM, the shift register, and bit_cnt.
// TESTING  (WIDTH=32, CLK_DIV=2 unless stated)
//  1. clear high for 2 cycles -> in_ready=1, sclk=0, sdata=0, frame=0, done=0.
//  2. Send 0xA5A50F0F. The bench samples sdata on each sclk rising edge and
//     must rebuild 0xA5A50F0F. done is high exactly at cycle 129 after accept.
//  3. Hold in_valid high and send 0x12345678, then 0xDEADBEEF.
//     -> Two frames, both correct. The second accept happens 1 cycle after
//     the done pulse. frame is low for 2 cycles between them.
//  4. Mid-frame, drive in_valid=1 with data_in=0xFFFFFFFF.
//     -> Ignored; the frame in progress is unchanged.
//  5. abort at cycle 40 of a frame -> next cycle frame=0, sclk=0, in_ready=1.
//     done never pulses.
//  6. clear at cycle 60 of a frame -> reset values on the next edge.
//     Then, with CLK_DIV=1, send 0x80000001: bits match and done is high at
//     cycle 65.

Source files
------------

// File: rtl/reg_32b_serial_tx_pkg.sv
// Shared definitions for the register-word serial link.
// The state encoding is shared with the future serial RX block, so keep
// the numeric values fixed.
package reg_32b_serial_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } serial_state_e;

   // Default frame geometry: one full reg_32b word per frame and
   // CLK_DIV system clocks per sclk half-period.
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/reg_32b_serial_tx_tick_div.sv
// Free-running divider: one-cycle tick every DIV cycles while en is high.
// The count restarts from zero whenever en is low or clear is high, so the
// first tick after enabling always arrives DIV cycles later.
module reg_32b_serial_tx_tick_div #(
   parameter int DIV = 4
) (
   input  logic clock,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   // Count 0..DIV-1 while enabled; hold at zero otherwise.
   always_ff @(posedge clock) begin
      if (clear || !en) begin
         div_cnt <= '0;
      end else if (div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/reg_32b_serial_tx.sv
// Transmit end of the reg_32b data path: takes one word per handshake and
// shifts it out MSB-first on sclk/sdata/frame to the unlock-mechanism
// controller, pulsing done once the last bit has been clocked.
//
// Handshake: a word is accepted on a rising clock edge where
// in_valid && in_ready. in_ready is high only in IDLE and depends on the
// state register alone. data_in is not looked at again after acceptance,
// and in_valid outside IDLE is ignored (nothing is queued).
//
// WIDTH must be >= 2 and CLK_DIV >= 1.
module reg_32b_serial_tx
   import reg_32b_serial_tx_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             abort,
   output logic             sclk,
   output logic             sdata,
   output logic             frame,
   output logic             done,
   output logic [1:0]       state_dbg
);

   localparam int BW = $clog2(WIDTH) + 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   serial_state_e    state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             sclk_d, sdata_d, frame_d, done_d;
   logic             accept;
   logic             shifting;
   logic             half_tick;

   assign in_ready  = (state_q == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign shifting  = (state_q == ST_SHIFT);
   assign state_dbg = state_q;

   // The divider only runs in SHIFT, so it is already at zero on accept;
   // accept is folded into its clear anyway so every frame starts aligned.
   reg_32b_serial_tx_tick_div #(
      .DIV (CLK_DIV)
   ) u_tick_div (
      .clock (clock),
      .clear (clear || accept),
      .en    (shifting),
      .tick  (half_tick)
   );

   // State, shift register, bit counter and all link outputs.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         sclk      <= 1'b0;
         sdata     <= 1'b0;
         frame     <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         sclk      <= sclk_d;
         sdata     <= sdata_d;
         frame     <= frame_d;
         done      <= done_d;
      end
   end

   // Next state and next output values; everything holds unless a branch
   // below says otherwise, and done is a single-cycle pulse.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      sclk_d    = sclk;
      sdata_d   = sdata;
      frame_d   = frame;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // abort is not looked at here, so accept wins over abort.
            if (in_valid) begin
               state_d   = ST_SHIFT;
               shreg_d   = data_in;
               bit_cnt_d = '0;
               frame_d   = 1'b1;
               sclk_d    = 1'b0;
               sdata_d   = data_in[WIDTH-1];
            end
         end

         ST_SHIFT: begin
            if (abort) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               frame_d   = 1'b0;
               sclk_d    = 1'b0;
               sdata_d   = 1'b0;
            end else if (half_tick) begin
               if (!sclk) begin
                  // Rising edge: receiver samples the bit already on sdata.
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: end of the current bit.
                  sclk_d = 1'b0;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = ST_DONE;
                     sdata_d = 1'b0;
                     frame_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     shreg_d   = shreg_q << 1;
                     sdata_d   = shreg_q[WIDTH-2];
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end
            end
         end

         ST_DONE: begin
            // One cycle with done high, then ready for the next word.
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
         end

         default: begin
            state_d = ST_IDLE;
            frame_d = 1'b0;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_32b_serial_tx.sv
// Bench for reg_32b_serial_tx. Two instances share clock/clear/abort:
// index 0 runs with CLK_DIV=2, index 1 with CLK_DIV=1; use_fast selects
// which one receives in_valid. The driver pushes every word it expects to
// see completed into exp_q; the negedge monitor rebuilds each frame from
// sdata on sclk rising edges and checks it when done pulses.
module tb_reg_32b_serial_tx;
   import reg_32b_serial_tx_pkg::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          clear;
   logic          in_valid;
   logic          abort;
   logic [W-1:0]  data_in;
   logic          use_fast;

   logic [1:0] in_valid_w;
   logic [1:0] in_ready_w, sclk_w, sdata_w, frame_w, done_w;
   logic [1:0] state_w0, state_w1;

   assign in_valid_w[0] = in_valid && !use_fast;
   assign in_valid_w[1] = in_valid &&  use_fast;

   reg_32b_serial_tx #(.WIDTH(W), .CLK_DIV(2)) dut_slow (
      .clock     (clock),
      .clear     (clear),
      .in_valid  (in_valid_w[0]),
      .in_ready  (in_ready_w[0]),
      .data_in   (data_in),
      .abort     (abort),
      .sclk      (sclk_w[0]),
      .sdata     (sdata_w[0]),
      .frame     (frame_w[0]),
      .done      (done_w[0]),
      .state_dbg (state_w0)
   );

   reg_32b_serial_tx #(.WIDTH(W), .CLK_DIV(1)) dut_fast (
      .clock     (clock),
      .clear     (clear),
      .in_valid  (in_valid_w[1]),
      .in_ready  (in_ready_w[1]),
      .data_in   (data_in),
      .abort     (abort),
      .sclk      (sclk_w[1]),
      .sdata     (sdata_w[1]),
      .frame     (frame_w[1]),
      .done      (done_w[1]),
      .state_dbg (state_w1)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;
   int  tmo_cnt     = 0;   // written by driver only
   int  tmo_seen    = 0;   // written by monitor only
   bit  req_idle    = 1'b0;
   bit  req_sel     = 1'b0;
   bit  req_end     = 1'b0;
   bit  gap_check   = 1'b0;
   bit  gap_done    = 1'b0;

   function automatic void chk32(input string name, input logic [31:0] act,
                                 input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endfunction

   function automatic void chk1(input string name, input logic act, input logic expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
      end
   endfunction

   // Reference model of frame timing: accept edge, then 2*CLK_DIV*W shift
   // cycles, then done in the following cycle.
   function automatic int done_cycle(input int idx);
      int div;
      div = (idx == 0) ? 2 : 1;
      return 2 * div * W + 1;
   endfunction

   // ---------------- monitor ----------------
   int           cyc[2];
   bit           pend[2];
   logic [W-1:0] rebuilt[2];
   int           nbits[2];
   logic         prev_sclk[2];
   bit           armed    = 1'b0;
   int           low_run  = 0;
   int           since_done = 0;

   // Sample everything on the falling edge, midway between driver updates.
   always @(negedge clock) begin
      logic [W-1:0] w;
      logic [1:0]   st;
      if (tmo_cnt != tmo_seen) begin
         vectors++;
         miscompares++;
         $display("FAIL handshake_timeout: got %0d expired waits expected 0", tmo_cnt);
         tmo_seen = tmo_cnt;
      end
      if (req_idle) begin
         st = req_sel ? state_w1 : state_w0;
         chk1("idle_in_ready", in_ready_w[req_sel], 1'b1);
         chk1("idle_sclk",     sclk_w[req_sel],     1'b0);
         chk1("idle_sdata",    sdata_w[req_sel],    1'b0);
         chk1("idle_frame",    frame_w[req_sel],    1'b0);
         chk1("idle_done",     done_w[req_sel],     1'b0);
         chk32("idle_state",   32'(st),             32'(ST_IDLE));
      end
      if (req_end) begin
         chk32("queue_drained", 32'(exp_q.size()), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         if (clear) begin
            cyc[i] = 0; pend[i] = 1'b0; nbits[i] = 0;
            rebuilt[i] = '0; prev_sclk[i] = 1'b0;
            continue;
         end
         if (pend[i]) begin
            cyc[i] = 1; pend[i] = 1'b0; nbits[i] = 0; rebuilt[i] = '0;
         end else if (cyc[i] > 0) begin
            cyc[i]++;
         end
         if (cyc[i] == 1) begin
            chk1("first_cycle_frame", frame_w[i], 1'b1);
            chk1("first_cycle_sclk",  sclk_w[i],  1'b0);
            if (exp_q.size() > 0) begin
               w = exp_q[0];
               chk1("first_cycle_msb", sdata_w[i], w[W-1]);
            end
         end
         if (cyc[i] > 0 && sclk_w[i] && !prev_sclk[i]) begin
            rebuilt[i] = {rebuilt[i][W-2:0], sdata_w[i]};
            nbits[i]++;
         end
         prev_sclk[i] = sclk_w[i];
         if (i == 0 && armed) begin
            since_done++;
            if (!frame_w[0]) begin
               low_run++;
            end else begin
               chk32("frame_gap", 32'(low_run), 32'd2);
               armed    = 1'b0;
               gap_done = 1'b1;
            end
         end
         if (done_w[i]) begin
            if (exp_q.size() == 0) begin
               chk1("done_without_frame", done_w[i], 1'b0);
            end else begin
               w = exp_q.pop_front();
               chk32("frame_data", rebuilt[i], w);
               chk32("done_cycle", 32'(cyc[i]), 32'(done_cycle(i)));
               chk32("bit_count",  32'(nbits[i]), 32'(W));
               chk1("done_frame", frame_w[i], 1'b0);
               chk1("done_sclk",  sclk_w[i],  1'b0);
               chk1("done_sdata", sdata_w[i], 1'b0);
            end
            cyc[i] = 0;
            if (i == 0 && gap_check && !gap_done) begin
               armed = 1'b1; low_run = 1; since_done = 0;
            end
         end else if (cyc[i] > 1 && !frame_w[i]) begin
            cyc[i] = 0;   // frame dropped by abort
         end
         if (in_valid_w[i] && in_ready_w[i]) begin
            pend[i] = 1'b1;
            if (i == 0 && armed) chk32("accept_after_done", 32'(since_done), 32'd1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic rdy();
      return use_fast ? in_ready_w[1] : in_ready_w[0];
   endfunction

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_idle(input bit sel);
      req_sel  = sel;
      req_idle = 1'b1;
      step(1);
      req_idle = 1'b0;
   endtask

   // Offer a word; returns 1 time unit after the accepting edge.
   task automatic send(input logic [W-1:0] w, input bit push, input bit keep_valid);
      bit got;
      got      = 1'b0;
      in_valid = 1'b1;
      data_in  = w;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clock);
         if (rdy()) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         tmo_cnt++;
         in_valid = 1'b0;
         return;
      end
      if (push) exp_q.push_back(w);
      @(posedge clock);
      #1;
      if (!keep_valid) begin
         in_valid = 1'b0;
         data_in  = $urandom;
      end
   endtask

   task automatic wait_drained(input int n);
      for (int k = 0; k < n; k++) begin
         step(1);
         if (exp_q.size() == 0 && rdy()) return;
      end
      tmo_cnt++;
   endtask

   // Random frames with optional mid-frame in_valid noise and idle aborts.
   task automatic random_frames(input int n);
      logic [W-1:0] w;
      for (int f = 0; f < n; f++) begin
         w = $urandom;
         if ($urandom_range(0, 3) == 0) abort = 1'b1;
         send(w, 1'b1, 1'b0);
         abort = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            step($urandom_range(2, 20));
            in_valid = 1'b1;
            data_in  = $urandom;
            step($urandom_range(1, 30));
            in_valid = 1'b0;
         end
         wait_drained(400);
         step($urandom_range(0, 3));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      clear    = 1'b1;
      in_valid = 1'b0;
      abort    = 1'b0;
      data_in  = '0;
      use_fast = 1'b0;
      step(2);
      clear = 1'b0;
      pulse_idle(1'b0);
      pulse_idle(1'b1);

      // Single known word.
      send(32'hA5A50F0F, 1'b1, 1'b0);
      wait_drained(400);
      step(2);

      // Back-to-back with in_valid held high across the frame.
      gap_check = 1'b1;
      send(32'h12345678, 1'b1, 1'b1);
      send(32'hDEADBEEF, 1'b1, 1'b0);
      wait_drained(400);
      gap_check = 1'b0;
      step(2);

      // Mid-frame in_valid with all-ones data is ignored.
      send(32'h3C96_5AA5, 1'b1, 1'b0);
      step(20);
      in_valid = 1'b1;
      data_in  = 32'hFFFFFFFF;
      step(30);
      in_valid = 1'b0;
      wait_drained(400);
      step(2);

      // Abort at cycle 40 of a frame: no done may follow.
      send($urandom, 1'b0, 1'b0);
      step(39);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      pulse_idle(1'b0);
      step(300);

      random_frames(5);

      // clear at cycle 60 of a frame.
      send($urandom, 1'b0, 1'b0);
      step(59);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      pulse_idle(1'b0);
      step(150);

      // CLK_DIV=1 instance.
      use_fast = 1'b1;
      send(32'h80000001, 1'b1, 1'b0);
      wait_drained(200);
      step(2);
      random_frames(6);

      step(5);
      req_end = 1'b1;
      step(1);
      req_end = 1'b0;
      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
